id_ex_stage: RTL

ID/EX pipeline stage that registers one decoded instruction and presents ALU-ready operands and control to the execute-stage ALU. It holds the instruction under downstream back-pressure and squashes it on flush. It resolves RAW hazards by forwarding from the MEM and WB stages, and refreshes held operands from WB so a retiring producer is not lost during a stall. It sits between the decoder/register file and the ALU (ALUop, funct3, ALUctl, data1, data2 consumer).

---
 rtl/id_ex_if.sv | 56 +++++
 rtl/id_ex_stage.sv | 112 +++++++++++
 2 files changed

// File: rtl/id_ex_if.sv
// ID/EX stage bus: upstream handshake and decoded fields, MEM/WB bypass inputs,
// and the execute-side handshake with ALU-ready operands.
interface id_ex_if #(
   parameter int unsigned XLEN = 32
) ();
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      id_ALUop;
   logic [2:0]      id_funct3;
   logic [4:0]      id_ALUctl;
   logic [4:0]      id_rs1_addr;
   logic [4:0]      id_rs2_addr;
   logic [4:0]      id_rd_addr;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;
   logic [XLEN-1:0] id_pc;
   logic            id_use_imm;
   logic            mem_fwd_valid;
   logic [4:0]      mem_rd_addr;
   logic [XLEN-1:0] mem_rd_data;
   logic            wb_fwd_valid;
   logic [4:0]      wb_rd_addr;
   logic [XLEN-1:0] wb_rd_data;
   logic            ex_valid;
   logic            ex_ready;
   logic [2:0]      ex_ALUop;
   logic [2:0]      ex_funct3;
   logic [4:0]      ex_ALUctl;
   logic [XLEN-1:0] ex_data1;
   logic [XLEN-1:0] ex_data2;
   logic [XLEN-1:0] ex_store_data;
   logic [4:0]      ex_rd_addr;
   logic [XLEN-1:0] ex_pc;

   modport master (
      output flush, in_valid, id_ALUop, id_funct3, id_ALUctl,
             id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data,
             id_imm, id_pc, id_use_imm,
             mem_fwd_valid, mem_rd_addr, mem_rd_data,
             wb_fwd_valid, wb_rd_addr, wb_rd_data, ex_ready,
      input  in_ready, ex_valid, ex_ALUop, ex_funct3, ex_ALUctl,
             ex_data1, ex_data2, ex_store_data, ex_rd_addr, ex_pc
   );

   modport slave (
      input  flush, in_valid, id_ALUop, id_funct3, id_ALUctl,
             id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data,
             id_imm, id_pc, id_use_imm,
             mem_fwd_valid, mem_rd_addr, mem_rd_data,
             wb_fwd_valid, wb_rd_addr, wb_rd_data, ex_ready,
      output in_ready, ex_valid, ex_ALUop, ex_funct3, ex_ALUctl,
             ex_data1, ex_data2, ex_store_data, ex_rd_addr, ex_pc
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and WB refresh of held operands.
// Bypass logic is present only when ID_EX_FWD_EN is defined; otherwise outputs are stored data.
module id_ex_stage (
   input logic   clk,
   input logic   rst_n,
   id_ex_if.slave bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;

   logic            r_valid;
   logic [2:0]      r_alu_op;
   logic [2:0]      r_funct3;
   logic [4:0]      r_alu_ctl;
   logic [RW-1:0]   r_rs1_addr;
   logic [RW-1:0]   r_rs2_addr;
   logic [RW-1:0]   r_rd_addr;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_pc;
   logic            r_use_imm;

   logic            w_accept;
   logic [XLEN-1:0] w_load_rs1;
   logic [XLEN-1:0] w_load_rs2;
   logic [XLEN-1:0] w_held_rs1;
   logic [XLEN-1:0] w_held_rs2;
   logic [XLEN-1:0] w_fwd_rs1;
   logic [XLEN-1:0] w_fwd_rs2;

   assign bus.in_ready = !r_valid || bus.ex_ready;
   assign w_accept     = bus.in_valid && bus.in_ready;

`ifdef ID_EX_FWD_EN
   logic w_wb_id1, w_wb_id2, w_wb_q1, w_wb_q2, w_mem_q1, w_mem_q2;

   assign w_wb_id1 = bus.wb_fwd_valid && (bus.wb_rd_addr == bus.id_rs1_addr) && (bus.id_rs1_addr != '0);
   assign w_wb_id2 = bus.wb_fwd_valid && (bus.wb_rd_addr == bus.id_rs2_addr) && (bus.id_rs2_addr != '0);
   assign w_wb_q1  = bus.wb_fwd_valid && (bus.wb_rd_addr == r_rs1_addr) && (r_rs1_addr != '0);
   assign w_wb_q2  = bus.wb_fwd_valid && (bus.wb_rd_addr == r_rs2_addr) && (r_rs2_addr != '0);
   assign w_mem_q1 = bus.mem_fwd_valid && (bus.mem_rd_addr == r_rs1_addr) && (r_rs1_addr != '0);
   assign w_mem_q2 = bus.mem_fwd_valid && (bus.mem_rd_addr == r_rs2_addr) && (r_rs2_addr != '0);

   assign w_load_rs1 = w_wb_id1 ? bus.wb_rd_data : bus.id_rs1_data;
   assign w_load_rs2 = w_wb_id2 ? bus.wb_rd_data : bus.id_rs2_data;
   // WB-refreshed stored value doubles as the low-priority leg of the forward mux
   assign w_held_rs1 = w_wb_q1 ? bus.wb_rd_data : r_rs1_data;
   assign w_held_rs2 = w_wb_q2 ? bus.wb_rd_data : r_rs2_data;
   assign w_fwd_rs1  = w_mem_q1 ? bus.mem_rd_data : w_held_rs1;
   assign w_fwd_rs2  = w_mem_q2 ? bus.mem_rd_data : w_held_rs2;
`else
   logic w_unused_bypass;

   assign w_unused_bypass = ^{bus.mem_fwd_valid, bus.mem_rd_addr, bus.mem_rd_data,
                              bus.wb_fwd_valid, bus.wb_rd_addr, bus.wb_rd_data};
   assign w_load_rs1 = bus.id_rs1_data;
   assign w_load_rs2 = bus.id_rs2_data;
   assign w_held_rs1 = r_rs1_data;
   assign w_held_rs2 = r_rs2_data;
   assign w_fwd_rs1  = r_rs1_data;
   assign w_fwd_rs2  = r_rs2_data;
`endif

   // Single-entry register: flush > accept > drain > hold (with refresh)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_alu_op   <= '0;
         r_funct3   <= '0;
         r_alu_ctl  <= '0;
         r_rs1_addr <= '0;
         r_rs2_addr <= '0;
         r_rd_addr  <= '0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_pc       <= '0;
         r_use_imm  <= 1'b0;
      end else if (bus.flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid    <= 1'b1;
         r_alu_op   <= bus.id_ALUop;
         r_funct3   <= bus.id_funct3;
         r_alu_ctl  <= bus.id_ALUctl;
         r_rs1_addr <= bus.id_rs1_addr;
         r_rs2_addr <= bus.id_rs2_addr;
         r_rd_addr  <= bus.id_rd_addr;
         r_rs1_data <= w_load_rs1;
         r_rs2_data <= w_load_rs2;
         r_imm      <= bus.id_imm;
         r_pc       <= bus.id_pc;
         r_use_imm  <= bus.id_use_imm;
      end else if (r_valid && bus.ex_ready) begin
         r_valid <= 1'b0;
      end else if (r_valid) begin
         r_rs1_data <= w_held_rs1;
         r_rs2_data <= w_held_rs2;
      end
   end

   assign bus.ex_valid      = r_valid;
   assign bus.ex_ALUop      = r_alu_op;
   assign bus.ex_funct3     = r_funct3;
   assign bus.ex_ALUctl     = r_alu_ctl;
   assign bus.ex_rd_addr    = r_rd_addr;
   assign bus.ex_pc         = r_pc;
   assign bus.ex_data1      = w_fwd_rs1;
   assign bus.ex_data2      = r_use_imm ? r_imm : w_fwd_rs2;
   assign bus.ex_store_data = w_fwd_rs2;
endmodule
